// File: rtl/tap_delay_line.sv
// Parametrised sample delay line feeding the FIR MAC sequencer.
// Accepts one sample per handshake, then sweeps all taps out serially.
//
// Ports:
//   clk, rst      clock (rising edge), async active-high reset
//   clear         sync clear of line, fill counter and sweep
//   in_valid/in_ready/in_data       sample input handshake
//   tap_valid/tap_ready/tap_data    serial tap output handshake
//   tap_idx       tap position (0 = newest), tap_last at SIZE-1
//   tail_out      oldest word line[SIZE-1]
//   fill_count    samples held (saturates at SIZE), primed when full
module tap_delay_line #(
  parameter int SIZE      = 8,
  parameter int BIT_WIDTH = 8,
  localparam int IW       = $clog2(SIZE),
  localparam int FW       = $clog2(SIZE+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 tap_valid,
  input  logic                 tap_ready,
  output logic [BIT_WIDTH-1:0] tap_data,
  output logic [IW-1:0]        tap_idx,
  output logic                 tap_last,
  output logic [BIT_WIDTH-1:0] tail_out,
  output logic [FW-1:0]        fill_count,
  output logic                 primed
);

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  state_t               r_state;
  logic [BIT_WIDTH-1:0] r_line [SIZE];
  logic [IW-1:0]        r_idx;
  logic [FW-1:0]        r_fill;

  logic w_accept;
  logic w_tap_hs;
  logic w_at_last;

  assign w_accept  = in_valid & (r_state == S_IDLE);
  assign w_tap_hs  = tap_ready & (r_state == S_SWEEP);
  assign w_at_last = (r_idx == IW'(SIZE-1));

  // clear outranks accept and tap handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_fill  <= '0;
      for (int i = 0; i < SIZE; i++)
        r_line[i] <= '0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_fill  <= '0;
      for (int i = 0; i < SIZE; i++)
        r_line[i] <= '0;
    end else if (w_accept) begin
      r_line[0] <= in_data;
      for (int i = 1; i < SIZE; i++)
        r_line[i] <= r_line[i-1];
      r_idx   <= '0;
      r_state <= S_SWEEP;
      if (r_fill != FW'(SIZE))
        r_fill <= r_fill + FW'(1);
    end else if (w_tap_hs) begin
      if (w_at_last) begin
        r_idx   <= '0;
        r_state <= S_IDLE;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign tap_valid  = (r_state == S_SWEEP);
  assign tap_idx    = r_idx;
  assign tap_last   = tap_valid & w_at_last;
  // gated so the idle bus reads zero rather than a stale word
  assign tap_data   = tap_valid ? r_line[r_idx] : '0;
  assign tail_out   = r_line[SIZE-1];
  assign fill_count = r_fill;
  assign primed     = (r_fill == FW'(SIZE));

endmodule

// File: tb/tb_tap_delay_line.sv
// Bench for tap_delay_line: directed table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_tap_delay_line;

  localparam int S  = 4;
  localparam int BW = 8;
  localparam int IW = $clog2(S);
  localparam int FW = $clog2(S+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          tap_valid;
  logic          tap_ready = 1'b0;
  logic [BW-1:0] tap_data;
  logic [IW-1:0] tap_idx;
  logic          tap_last;
  logic [BW-1:0] tail_out;
  logic [FW-1:0] fill_count;
  logic          primed;

  tap_delay_line #(.SIZE(S), .BIT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tap_valid(tap_valid), .tap_ready(tap_ready),
    .tap_data(tap_data), .tap_idx(tap_idx), .tap_last(tap_last),
    .tail_out(tail_out), .fill_count(fill_count), .primed(primed)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // reference model: newest word at the front of the queue
  logic [BW-1:0] m_q[$];
  bit            m_sweep;
  int            m_idx;
  int            m_fill;
  int            acc_cyc[$];

  typedef struct {
    logic [BW-1:0] d;
    int            fill;
    logic [BW-1:0] tail;
    logic          prm;
    logic [BW-1:0] taps [S];
  } vec_t;

  vec_t tbl [6];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < S; i++) m_q.push_back('0);
    m_sweep = 0;
    m_idx   = 0;
    m_fill  = 0;
  endtask

  task automatic model_check();
    check("in_ready", 32'(in_ready), 32'(!m_sweep));
    check("tap_valid", 32'(tap_valid), 32'(m_sweep));
    check("fill", 32'(fill_count), 32'(m_fill));
    check("primed", 32'(primed), 32'(m_fill == S));
    check("tail", 32'(tail_out), 32'(m_q[S-1]));
    if (m_sweep) begin
      check("idx", 32'(tap_idx), 32'(m_idx));
      check("data", 32'(tap_data), 32'(m_q[m_idx]));
      check("last", 32'(tap_last), 32'(m_idx == S-1));
    end
  endtask

  task automatic step();
    bit acc, hs, clr;
    logic [BW-1:0] d;
    clr = clear;
    acc = in_valid && !m_sweep && !clr;
    hs  = m_sweep && tap_ready && !clr;
    d   = in_data;
    if (acc) acc_cyc.push_back(cyc);
    @(posedge clk);
    cyc++;
    if (clr) begin
      model_reset();
    end else if (acc) begin
      m_q.push_front(d);
      m_q.delete(S);
      if (m_fill < S) m_fill++;
      m_sweep = 1;
      m_idx   = 0;
    end else if (hs) begin
      if (m_idx == S-1) begin
        m_sweep = 0;
        m_idx   = 0;
      end else begin
        m_idx++;
      end
    end
    #1;
    model_check();
  endtask

  task automatic check_reset_outs();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_tap_valid", 32'(tap_valid), 32'd0);
    check("rst_tap_last", 32'(tap_last), 32'd0);
    check("rst_tap_data", 32'(tap_data), 32'd0);
    check("rst_tail", 32'(tail_out), 32'd0);
    check("rst_fill", 32'(fill_count), 32'd0);
    check("rst_primed", 32'(primed), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_outs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    tbl[0] = '{8'h11, 1, 8'h00, 1'b0, '{8'h11, 8'h00, 8'h00, 8'h00}};
    tbl[1] = '{8'h22, 2, 8'h00, 1'b0, '{8'h22, 8'h11, 8'h00, 8'h00}};
    tbl[2] = '{8'h33, 3, 8'h00, 1'b0, '{8'h33, 8'h22, 8'h11, 8'h00}};
    tbl[3] = '{8'h44, 4, 8'h11, 1'b1, '{8'h44, 8'h33, 8'h22, 8'h11}};
    tbl[4] = '{8'h55, 4, 8'h22, 1'b1, '{8'h55, 8'h44, 8'h33, 8'h22}};
    tbl[5] = '{8'h66, 4, 8'h33, 1'b1, '{8'h66, 8'h55, 8'h44, 8'h33}};

    apply_reset();

    // fill, order and tail via the table
    for (int v = 0; v < 6; v++) begin
      in_valid  = 1'b1;
      in_data   = tbl[v].d;
      tap_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("t_fill", 32'(fill_count), 32'(tbl[v].fill));
      check("t_tail", 32'(tail_out), 32'(tbl[v].tail));
      check("t_primed", 32'(primed), 32'(tbl[v].prm));
      for (int k = 0; k < S; k++) begin
        check("t_valid", 32'(tap_valid), 32'd1);
        check("t_data", 32'(tap_data), 32'(tbl[v].taps[k]));
        check("t_idx", 32'(tap_idx), 32'(k));
        check("t_last", 32'(tap_last), 32'(k == S-1));
        step();
      end
      check("t_done", 32'(in_ready), 32'd1);
    end

    // backpressure at idx 1; line is 77,66,55,44
    in_valid = 1'b1;
    in_data  = 8'h77;
    step();
    step();
    tap_ready = 1'b0;
    in_data   = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_idx", 32'(tap_idx), 32'd1);
      check("bp_data", 32'(tap_data), 32'h66);
      check("bp_rdy", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    tap_ready = 1'b1;
    check("bp_r1", 32'(tap_data), 32'h66);
    step();
    check("bp_r2", 32'(tap_data), 32'h55);
    step();
    check("bp_r3", 32'(tap_data), 32'h44);
    check("bp_last", 32'(tap_last), 32'd1);
    step();
    check("bp_end", 32'(in_ready), 32'd1);

    // clear at idx 2 with a sample offered
    in_valid = 1'b1;
    in_data  = 8'h88;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("cl_idx", 32'(tap_idx), 32'd2);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("cl_valid", 32'(tap_valid), 32'd0);
    check("cl_rdy", 32'(in_ready), 32'd1);
    check("cl_fill", 32'(fill_count), 32'd0);
    check("cl_tail", 32'(tail_out), 32'd0);
    step();
    check("cl_noacc", 32'(fill_count), 32'd0);

    // throughput with continuous in_valid
    acc_cyc  = {};
    in_valid = 1'b1;
    for (int k = 0; k < 24; k++) begin
      in_data = 8'(8'hA0 + k);
      step();
    end
    in_valid = 1'b0;
    check("tp_count", 32'(acc_cyc.size()), 32'd5);
    for (int k = 1; k < acc_cyc.size(); k++)
      check("tp_gap", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(S+1));

    // async reset mid-sweep
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid  = 1'b0;
    tap_ready = 1'b1;
    step();
    apply_reset();

    // random traffic
    for (int k = 0; k < 800; k++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      tap_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      step();
    end
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
